// File: rtl/cache_arbiter.sv
// Two-port arbiter that shares one physical-memory port between an I-cache and a D-cache.
// One transfer is in flight at a time, and an idle cycle always separates two transfers.
// Optional build macro: CACHE_ARB_ROUND_ROBIN_EN alternates tie grants using last_grant.
// When the macro is absent, a tie always goes to the D-cache.
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  // I-cache side
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  // D-cache side
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  // Shared physical memory
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    StIdle,
    StServeI,
    StServeD
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 0 = I-cache, 1 = D-cache
  logic   i_req, d_req;
  logic   tie_to_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // Give the tie to whichever cache was not granted last.
  assign tie_to_d = ~last_grant_q;
`else
  // Fixed D priority; last_grant is still tracked but cannot change the outcome.
  assign tie_to_d = 1'b1 | last_grant_q;
`endif

  // Fill data goes to both caches; only the granted one sees a resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  // State and last-grant registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state decision and memory-port steering.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
          state_d      = tie_to_d ? StServeD : StServeI;
          last_grant_d = tie_to_d;
        end else if (d_req) begin
          state_d      = StServeD;
          last_grant_d = 1'b1;
        end else if (i_req) begin
          state_d      = StServeI;
          last_grant_d = 1'b0;
        end
      end

      StServeI: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
        // Leave on completion or if the I-cache withdraws its request.
        if (pmem_resp || !i_pmem_read) begin
          state_d = StIdle;
        end
      end

      StServeD: begin
        // A simultaneous read and write is treated as a write.
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
        if (pmem_resp || !d_req) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus a randomized run
// checked against a bus-ownership reference model.
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int total = 0;
  int bad   = 0;

  cache_arbiter #(
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata  (i_pmem_rdata),
    .i_pmem_resp   (i_pmem_resp),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_rdata  (d_pmem_rdata),
    .d_pmem_resp   (d_pmem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp)
  );

  always #5 clk = ~clk;

  // Reference model: who currently owns the memory port (0 none, 1 I, 2 D),
  // and which cache won most recently (1 = D).
  int   m_own  = 0;
  bit   m_last = 1'b0;
  logic m_tie_d;
  assign m_tie_d = RR ? !m_last : 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      m_own  <= 0;
      m_last <= 1'b0;
    end else if (m_own == 0) begin
      if (i_pmem_read && (d_pmem_read || d_pmem_write)) begin
        m_own  <= m_tie_d ? 2 : 1;
        m_last <= m_tie_d;
      end else if (d_pmem_read || d_pmem_write) begin
        m_own  <= 2;
        m_last <= 1'b1;
      end else if (i_pmem_read) begin
        m_own  <= 1;
        m_last <= 1'b0;
      end
    end else if (m_own == 1) begin
      if (pmem_resp || !i_pmem_read) m_own <= 0;
    end else begin
      if (pmem_resp || !(d_pmem_read || d_pmem_write)) m_own <= 0;
    end
  end

  task automatic clear_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
  endtask

  // Leaves the DUT idle at a falling edge with reset low.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [LW-1:0] data;
    clear_inputs();
    reset        = 1'b1;
    i_pmem_read  = 1'b1;
    d_pmem_write = 1'b1;
    pmem_resp    = 1'b1;
    data         = {$urandom, $urandom, $urandom, $urandom};
    pmem_rdata   = data;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_strobes: got %b exp 0000",
               {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
    end
    total++;
    if (pmem_address !== '0 || pmem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_addr_wdata: got %h/%h exp 0/0", pmem_address, pmem_wdata);
    end
    total++;
    if (i_pmem_rdata !== data || d_pmem_rdata !== data) begin
      bad++;
      $display("FAIL rdata_passthru: got %h/%h exp %h", i_pmem_rdata, d_pmem_rdata, data);
    end
    // First cycle with reset low arbitrates: D write granted at the next edge.
    @(negedge clk);
    reset       = 1'b0;
    i_pmem_read = 1'b0;
    pmem_resp   = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (pmem_write !== 1'b1) begin
      bad++;
      $display("FAIL first_arb_after_reset: got pmem_write=%b exp 1", pmem_write);
    end
  endtask

  task automatic test_i_read();
    logic [LW-1:0] data;
    do_reset();
    i_pmem_address = 16'h1230;
    i_pmem_read    = 1'b1;
    #1;
    total++;
    if (pmem_read !== 1'b0) begin
      bad++;
      $display("FAIL i_grant_latency: got pmem_read=%b exp 0", pmem_read);
    end
    @(negedge clk);
    #1;
    total++;
    if ({pmem_read, pmem_write} !== 2'b10 || pmem_address !== 16'h1230) begin
      bad++;
      $display("FAIL i_serve_strobe: got rd=%b wr=%b addr=%h exp 1 0 1230",
               pmem_read, pmem_write, pmem_address);
    end
    @(negedge clk);
    #1;
    total++;
    if (i_pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL i_resp_early: got %b exp 0", i_pmem_resp);
    end
    @(negedge clk);
    data       = {$urandom, $urandom, $urandom, $urandom};
    pmem_rdata = data;
    pmem_resp  = 1'b1;
    #1;
    total++;
    if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0 || i_pmem_rdata !== data) begin
      bad++;
      $display("FAIL i_resp: got i=%b d=%b data=%h exp 1 0 %h",
               i_pmem_resp, d_pmem_resp, i_pmem_rdata, data);
    end
    @(negedge clk);
    pmem_resp   = 1'b0;
    i_pmem_read = 1'b0;
    #1;
    total++;
    if ({pmem_read, i_pmem_resp} !== 2'b00) begin
      bad++;
      $display("FAIL i_idle_after: got rd=%b resp=%b exp 0 0", pmem_read, i_pmem_resp);
    end
  endtask

  task automatic test_d_write();
    do_reset();
    d_pmem_address = 16'h4000;
    d_pmem_wdata   = {16{8'hA5}};
    d_pmem_write   = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({pmem_read, pmem_write} !== 2'b01 || pmem_address !== 16'h4000 ||
        pmem_wdata !== {16{8'hA5}}) begin
      bad++;
      $display("FAIL d_write_strobe: got rd=%b wr=%b addr=%h wd=%h exp 0 1 4000 a5..",
               pmem_read, pmem_write, pmem_address, pmem_wdata);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    total++;
    if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL d_write_resp: got d=%b i=%b exp 1 0", d_pmem_resp, i_pmem_resp);
    end
    @(negedge clk);
    pmem_resp    = 1'b0;
    d_pmem_write = 1'b0;
    #1;
    total++;
    if ({pmem_write, d_pmem_resp} !== 2'b00) begin
      bad++;
      $display("FAIL d_idle_after: got wr=%b resp=%b exp 0 0", pmem_write, d_pmem_resp);
    end
  endtask

  task automatic test_rw_both();
    do_reset();
    d_pmem_address = 16'h0550;
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({pmem_read, pmem_write} !== 2'b01) begin
      bad++;
      $display("FAIL rw_write_wins: got rd=%b wr=%b exp 0 1", pmem_read, pmem_write);
    end
  endtask

  task automatic test_tie();
    bit exp_d;
    do_reset();
    i_pmem_address = 16'h1000;
    d_pmem_address = 16'h2000;
    i_pmem_read    = 1'b1;
    d_pmem_read    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pmem_resp = 1'b1;
      exp_d     = RR ? (k % 2 == 0) : 1'b1;
      #1;
      total++;
      if (pmem_address !== (exp_d ? 16'h2000 : 16'h1000) ||
          (exp_d ? d_pmem_resp : i_pmem_resp) !== 1'b1) begin
        bad++;
        $display("FAIL tie_grant_%0d: got addr=%h i=%b d=%b exp_d=%b",
                 k, pmem_address, i_pmem_resp, d_pmem_resp, exp_d);
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      total++;
      if (pmem_read !== 1'b0) begin
        bad++;
        $display("FAIL tie_idle_gap_%0d: got pmem_read=%b exp 0", k, pmem_read);
      end
    end
  endtask

  task automatic test_wait();
    do_reset();
    d_pmem_address = 16'h2220;
    d_pmem_read    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_pmem_address = 16'h3330;
    i_pmem_read    = 1'b1;
    #1;
    total++;
    if (pmem_address !== 16'h2220 || i_pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL wait_d_keeps: got addr=%h i_resp=%b exp 2220 0", pmem_address, i_pmem_resp);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    total++;
    if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL wait_d_resp: got d=%b i=%b exp 1 0", d_pmem_resp, i_pmem_resp);
    end
    @(negedge clk);
    pmem_resp   = 1'b0;
    d_pmem_read = 1'b0;
    #1;
    total++;
    if (pmem_read !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: got pmem_read=%b exp 0", pmem_read);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h3330 || i_pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL wait_i_served: got rd=%b addr=%h resp=%b exp 1 3330 1",
               pmem_read, pmem_address, i_pmem_resp);
    end
  endtask

  task automatic test_abort();
    do_reset();
    i_pmem_address = 16'h0ab0;
    i_pmem_read    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_pmem_read = 1'b0;
    #1;
    total++;
    if (pmem_read !== 1'b0) begin
      bad++;
      $display("FAIL abort_strobe: got pmem_read=%b exp 0", pmem_read);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    total++;
    if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
      bad++;
      $display("FAIL abort_late_resp: got i=%b d=%b exp 0 0", i_pmem_resp, d_pmem_resp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_pmem_address = 16'h7770;
    d_pmem_read    = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (pmem_read !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: got pmem_read=%b exp 1", pmem_read);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    pmem_resp = 1'b1;  // late completion with the D request still held
    #1;
    total++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
      bad++;
      $display("FAIL midreset_idle: got %b exp 0000",
               {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
    end
  endtask

  task automatic test_random();
    bit            i_busy = 1'b0, d_busy = 1'b0, d_rd = 1'b0, d_wr = 1'b0, chk_wd;
    int            i_gap = 0, d_gap = 0, mem_cnt = 0, lat = 1, kind;
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (i_busy) begin
        if ($urandom_range(39, 0) == 0) begin
          i_busy = 1'b0;
          i_gap  = $urandom_range(2, 0);
        end
      end else if (i_gap > 0) begin
        i_gap--;
      end else if ($urandom_range(1, 0) == 1) begin
        i_busy         = 1'b1;
        i_pmem_address = AW'($urandom);
      end
      if (d_busy) begin
        if ($urandom_range(39, 0) == 0) begin
          d_busy = 1'b0;
          d_gap  = $urandom_range(2, 0);
        end
      end else if (d_gap > 0) begin
        d_gap--;
      end else if ($urandom_range(1, 0) == 1) begin
        d_busy         = 1'b1;
        kind           = $urandom_range(9, 0);
        d_wr           = (kind < 4);
        d_rd           = (kind >= 3);
        d_pmem_address = AW'($urandom);
        d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      i_pmem_read  = i_busy;
      d_pmem_read  = d_busy & d_rd;
      d_pmem_write = d_busy & d_wr;
      pmem_rdata   = {$urandom, $urandom, $urandom, $urandom};

      e_rd   = 1'b0;
      e_wr   = 1'b0;
      e_addr = '0;
      e_wd   = '0;
      chk_wd = 1'b1;
      if (m_own == 1) begin
        e_rd   = i_pmem_read;
        e_addr = i_pmem_address;
        chk_wd = 1'b0;
      end else if (m_own == 2) begin
        e_wr   = d_pmem_write;
        e_rd   = d_pmem_read & ~d_pmem_write;
        e_addr = d_pmem_address;
        e_wd   = d_pmem_wdata;
      end

      // Memory: completes after a random latency; occasional stray resp otherwise.
      if (e_rd || e_wr) begin
        if (mem_cnt == 0) lat = $urandom_range(4, 1);
        mem_cnt++;
        pmem_resp = (mem_cnt >= lat);
        if (pmem_resp) mem_cnt = 0;
      end else begin
        mem_cnt   = 0;
        pmem_resp = ($urandom_range(9, 0) == 0);
      end
      e_ir = (m_own == 1) && pmem_resp;
      e_dr = (m_own == 2) && pmem_resp;
      #1;
      total++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address} !==
          {e_rd, e_wr, e_ir, e_dr, e_addr}) begin
        bad++;
        $display("FAIL rand_ctrl cyc %0d: got rd%b wr%b ir%b dr%b a%h exp rd%b wr%b ir%b dr%b a%h",
                 c, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address,
                 e_rd, e_wr, e_ir, e_dr, e_addr);
      end
      if (chk_wd) begin
        total++;
        if (pmem_wdata !== e_wd) begin
          bad++;
          $display("FAIL rand_wdata cyc %0d: got %h exp %h", c, pmem_wdata, e_wd);
        end
      end
      total++;
      if (i_pmem_rdata !== pmem_rdata || d_pmem_rdata !== pmem_rdata) begin
        bad++;
        $display("FAIL rand_rdata cyc %0d: got %h/%h exp %h",
                 c, i_pmem_rdata, d_pmem_rdata, pmem_rdata);
      end
      if (e_ir) begin
        i_busy = 1'b0;
        i_gap  = $urandom_range(2, 0);
      end
      if (e_dr) begin
        d_busy = 1'b0;
        d_gap  = $urandom_range(2, 0);
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_rw_both();
    test_tie();
    test_wait();
    test_abort();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 16, width of the physical memory address.
REQ-002 Parameter LINE_WIDTH, 128, width of one cache line transfer.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_pmem_read  input  1  I-cache line-fill request; held until i_pmem_resp.
REQ-006 i_pmem_address  input  ADDR_WIDTH  I-cache line address.
REQ-007 i_pmem_rdata  output  LINE_WIDTH  fill data to the I-cache.
REQ-008 i_pmem_resp  output  1  I-cache transfer-complete pulse.
REQ-009 d_pmem_read  input  1  D-cache line-fill request; held until d_pmem_resp.
REQ-010 d_pmem_write  input  1  D-cache writeback request; held until d_pmem_resp.
REQ-011 d_pmem_address  input  ADDR_WIDTH  D-cache line address.
REQ-012 d_pmem_wdata  input  LINE_WIDTH  D-cache writeback data.
REQ-013 d_pmem_rdata  output  LINE_WIDTH  fill data to the D-cache.
REQ-014 d_pmem_resp  output  1  D-cache transfer-complete pulse.
REQ-015 pmem_read  output  1  shared-memory read strobe.
REQ-016 pmem_write  output  1  shared-memory write strobe.
REQ-017 pmem_address  output  ADDR_WIDTH  shared-memory address.
REQ-018 pmem_wdata  output  LINE_WIDTH  shared-memory write data.
REQ-019 pmem_rdata  input  LINE_WIDTH  shared-memory read data.
REQ-020 pmem_resp  input  1  shared-memory completion; valid for one cycle.

Function
REQ-021 The block SHALL implement a three-state FSM: IDLE, SERVE_I and SERVE_D.
REQ-022 In IDLE, pmem_read, pmem_write, i_pmem_resp and d_pmem_resp SHALL be 0 and pmem_address/pmem_wdata SHALL be 0.
REQ-023 From IDLE, the FSM SHALL go to SERVE_I if only i_pmem_read is set, to SERVE_D if only d_pmem_read or d_pmem_write is set, and stay in IDLE if there are no requests; the grant decision takes one cycle.
REQ-024 When both caches request in IDLE, the FSM SHALL select the winner by the tie rule in Configuration.
REQ-025 In SERVE_I, pmem_read SHALL equal i_pmem_read, pmem_write SHALL be 0 and pmem_address SHALL equal i_pmem_address, all combinational.
REQ-026 In SERVE_D, pmem_write SHALL equal d_pmem_write, pmem_read SHALL equal d_pmem_read & ~d_pmem_write, pmem_address SHALL equal d_pmem_address and pmem_wdata SHALL equal d_pmem_wdata; on a simultaneous read and write, the write wins.
REQ-027 i_pmem_rdata and d_pmem_rdata SHALL both equal pmem_rdata at all times.
REQ-028 pmem_resp SHALL be forwarded to the granted cache's resp in the same cycle only; the other cache's resp SHALL stay 0.
REQ-029 On pmem_resp, the FSM SHALL return to IDLE at the next edge, so there is at least one idle cycle between transfers.
REQ-030 If the granted requester deasserts its request before pmem_resp, the FSM SHALL return to IDLE at the next edge, and any later pmem_resp SHALL be ignored.
REQ-031 A request arriving during service of the other cache SHALL wait without loss and SHALL be granted from the next IDLE.
REQ-032 Register last_grant (0 = I, 1 = D) SHALL update on every IDLE -> SERVE_x transition.

Reset
REQ-033 While reset is high at a clock edge, the FSM SHALL enter IDLE and last_grant SHALL become 0, including mid-transfer; all outputs SHALL be 0 in the following cycle.
REQ-034 After reset deasserts, the first arbitration SHALL take place in the first cycle with reset low.

Configuration
REQ-035 Macro CACHE_ARB_ROUND_ROBIN_EN: when defined, a tie SHALL be granted to the cache not recorded in last_grant, so D wins the first tie after reset.
REQ-036 Without CACHE_ARB_ROUND_ROBIN_EN, a tie SHALL always be granted to the D-cache, and last_grant SHALL have no functional effect.

Verification
REQ-037 Reset, then i_pmem_read=1 at address 0x1230 with memory latency 3 -> pmem_read=1 and pmem_address=0x1230 from cycle 1; i_pmem_resp pulses once with pmem_rdata; IDLE follows.
REQ-038 d_pmem_write=1 at address 0x4000 with wdata 0xA5..A5 -> pmem_write=1 and pmem_wdata matches; d_pmem_resp pulses once; i_pmem_resp stays 0.
REQ-039 Both caches request continuously after reset -> with the macro: grants go D, I, D, I; without the macro: every grant goes to D while d_pmem_read is held.
REQ-040 i_pmem_read is raised during a D transfer -> the I transfer is served after the D resp plus one IDLE cycle, and no request is dropped.
REQ-041 Reset is asserted in SERVE_D mid-transfer -> next cycle pmem_read=0 and pmem_write=0, the state is IDLE, and a late pmem_resp produces no cache resp.
REQ-042 d_pmem_read and d_pmem_write are both 1 -> pmem_write=1 and pmem_read=0.
